capture_ctrl: RTL and testbench

Sequences oscilloscope acquisition into the write side of the asynchronous sample FIFO. Runs in the ADC/write clock domain. Watches the incoming sample stream for a level-crossing trigger, then gates exactly `post_len` samples into the FIFO by driving the write-pointer increment and write data. Reports acquisition status and FIFO overflow to the control logic.

---
 rtl/capture_ctrl.sv | 145 ++++++++++++++
 tb/tb_capture_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Oscilloscope acquisition sequencer: detects a level-crossing trigger on the ADC
// stream and then writes exactly post_len samples into the asynchronous FIFO's write side.
module capture_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] trig_level_i,
    input  logic                  trig_edge_i,
    input  logic                  trig_force_i,
    input  logic [CNT_WIDTH-1:0]  post_len_i,
    input  logic                  fifo_full_i,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  triggered_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  wr_en_q, wr_en_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  trig_q, trig_d;
    logic                  done_q, done_d;
    logic                  hit;
    logic                  take;
    logic [CNT_WIDTH:0]    cnt_inc;

    // Extra MSB keeps the increment from wrapping before the length compare.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);

    always_comb begin
        hit = trig_force_i;
        if (prev_vld_q) begin
            if (!trig_edge_i && (prev_q < trig_level_i) && (sample_i >= trig_level_i)) hit = 1'b1;
            if (trig_edge_i && (prev_q > trig_level_i) && (sample_i <= trig_level_i)) hit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        ovf_d      = ovf_q;
        take       = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (arm_i && (post_len_i != '0)) begin
                        state_d    = ARMED;
                        len_d      = post_len_i;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        prev_vld_d = 1'b0;
                    end
                end
                ARMED: begin
                    if (sample_valid_i) begin
                        prev_d     = sample_i;
                        prev_vld_d = 1'b1;
                        if (hit) begin
                            state_d = CAPTURE;
                            take    = 1'b1;
                        end
                    end
                end
                CAPTURE: take = sample_valid_i;
                default: state_d = IDLE;
            endcase

            // The triggering sample goes through the same write/drop path as the rest.
            if (take) begin
                if (fifo_full_i) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = sample_i;
                    cnt_d     = cnt_inc[CNT_WIDTH-1:0];
                    if (cnt_inc == {1'b0, len_q}) state_d = DONE;
                end
            end
        end

        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
        trig_d = (state_d == CAPTURE) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            trig_q     <= trig_d;
            done_q     <= done_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign triggered_o = trig_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus a randomized run, all compared
// cycle by cycle against an acquisition model kept in the bench.
module tb_capture_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        arm_i, abort_i, sample_valid_i, trig_edge_i, trig_force_i, fifo_full_i;
    logic [7:0]  sample_i, trig_level_i;
    logic [11:0] post_len_i;
    logic        wr_en_o, busy_o, triggered_o, done_o, overflow_o;
    logic [7:0]  wr_data_o;

    int checks = 0;
    int errors = 0;

    capture_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .trig_level_i(trig_level_i), .trig_edge_i(trig_edge_i),
        .trig_force_i(trig_force_i), .post_len_i(post_len_i),
        .fifo_full_i(fifo_full_i), .wr_en_o(wr_en_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .triggered_o(triggered_o), .done_o(done_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Acquisition model: phase of the acquisition, samples taken so far, last sample seen.
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_CAPTURE = 2, PH_DONE = 3;
    int m_phase, m_len, m_taken, m_prev, m_data;
    bit m_have_prev, m_wr, m_ovf;
    logic [7:0] seen[$];

    function automatic void model_reset();
        m_phase = PH_IDLE; m_len = 0; m_taken = 0; m_prev = 0; m_data = 0;
        m_have_prev = 0; m_wr = 0; m_ovf = 0;
    endfunction

    function automatic void model_accept(input int s, input bit full);
        if (full) m_ovf = 1;
        else begin
            m_wr = 1; m_data = s; m_taken++;
            if (m_taken == m_len) m_phase = PH_DONE;
        end
    endfunction

    function automatic void model_cycle(input bit arm, abort, valid, input int s, input bit full, force_t);
        bit crossed;
        m_wr = 0;
        if (abort) m_phase = PH_IDLE;
        else if ((m_phase == PH_IDLE || m_phase == PH_DONE) && arm && post_len_i != 0) begin
            m_phase = PH_ARMED; m_len = int'(post_len_i); m_taken = 0; m_ovf = 0; m_have_prev = 0;
        end else if (m_phase == PH_ARMED && valid) begin
            if (trig_edge_i) crossed = m_have_prev && m_prev > int'(trig_level_i) && s <= int'(trig_level_i);
            else crossed = m_have_prev && m_prev < int'(trig_level_i) && s >= int'(trig_level_i);
            m_prev = s; m_have_prev = 1;
            if (crossed || force_t) begin
                m_phase = PH_CAPTURE;
                model_accept(s, full);
            end
        end else if (m_phase == PH_CAPTURE && valid) model_accept(s, full);
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_wr, 8'(m_data), (m_phase == PH_ARMED || m_phase == PH_CAPTURE),
                (m_phase == PH_CAPTURE || m_phase == PH_DONE), (m_phase == PH_DONE), m_ovf};
    endfunction

    task automatic step(input bit arm, abort, valid, input int s, input bit full, force_t);
        @(negedge clk_i);
        arm_i = arm; abort_i = abort; sample_valid_i = valid; sample_i = 8'(s);
        fifo_full_i = full; trig_force_i = force_t;
        model_cycle(arm, abort, valid, s, full, force_t);
        @(posedge clk_i);
        #1;
        if (wr_en_o) seen.push_back(wr_data_o);
    endtask

    task automatic test_reset();
        rst_i = 1; arm_i = 0; abort_i = 0; sample_valid_i = 0; sample_i = 0;
        trig_level_i = 0; trig_edge_i = 0; trig_force_i = 0; post_len_i = 0; fifo_full_i = 0;
        model_reset();
        #12;
        checks++;
        if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset: got %h expected %h", {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, 13'h0);
        end
        @(negedge clk_i); rst_i = 0;
        step(0, 0, 1, 200, 0, 1);
        checks++;
        if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
        end
    endtask

    task automatic test_rising();
        int ramp[7] = '{90, 95, 105, 110, 115, 120, 125};
        int want[4] = '{105, 110, 115, 120};
        trig_level_i = 100; trig_edge_i = 0; post_len_i = 4;
        step(1, 0, 0, 0, 0, 0);
        seen.delete();
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, ramp[i], 0, 0);
            checks++;
            if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
                errors++;
                $display("FAIL rising[%0d]: got %h expected %h", i, {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
            end
            if (i == 5) begin
                checks++;
                if (!(done_o === 1'b1 && wr_en_o === 1'b1 && wr_data_o === 8'd120)) begin
                    errors++;
                    $display("FAIL rising_done: got done=%b wr_en=%b data=%0d expected 1 1 120", done_o, wr_en_o, wr_data_o);
                end
            end
        end
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL rising_count: got %0d expected 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== 8'(want[i])) begin
                    errors++;
                    $display("FAIL rising_data[%0d]: got %0d expected %0d", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_falling();
        int smp[4] = '{40, 60, 50, 40};
        trig_level_i = 50; trig_edge_i = 1; post_len_i = 2;
        step(1, 0, 0, 0, 0, 0);
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, smp[i], 0, 0);
            checks++;
            if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
                errors++;
                $display("FAIL falling[%0d]: got %h expected %h", i, {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (triggered_o !== 1'b0 || wr_en_o !== 1'b0) begin
                    errors++;
                    $display("FAIL falling_first: got trig=%b wr_en=%b expected 0 0", triggered_o, wr_en_o);
                end
            end
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 8'd50) begin
            errors++;
            $display("FAIL falling_first_write: got n=%0d first=%0d expected n=2 first=50", seen.size(), seen.size() ? seen[0] : 0);
        end
    endtask

    task automatic test_overflow();
        int smp[5] = '{11, 22, 33, 44, 55};
        trig_level_i = 200; trig_edge_i = 0; post_len_i = 3;
        step(1, 0, 0, 0, 0, 0);
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, smp[i], i == 1, i == 0);
            checks++;
            if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
                errors++;
                $display("FAIL overflow[%0d]: got %h expected %h", i, {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
            end
        end
        checks++;
        if (overflow_o !== 1'b1 || done_o !== 1'b1 || seen.size() != 3) begin
            errors++;
            $display("FAIL overflow_summary: got ovf=%b done=%b writes=%0d expected 1 1 3", overflow_o, done_o, seen.size());
        end
        foreach (seen[i]) begin
            checks++;
            if (seen[i] === 8'd22) begin
                errors++;
                $display("FAIL overflow_dropped: got 22 written expected never");
            end
        end
    endtask

    task automatic test_rearm();
        post_len_i = 2; trig_level_i = 200; trig_edge_i = 0;
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (overflow_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rearm_clear: got ovf=%b done=%b busy=%b expected 0 0 1", overflow_o, done_o, busy_o);
        end
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 7 + i, 0, i == 0);
            checks++;
            if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
                errors++;
                $display("FAIL rearm[%0d]: got %h expected %h", i, {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
            end
        end
        checks++;
        if (done_o !== 1'b1 || seen.size() != 2) begin
            errors++;
            $display("FAIL rearm_done: got done=%b writes=%0d expected 1 2", done_o, seen.size());
        end
    endtask

    task automatic test_force_abort();
        step(0, 1, 0, 0, 0, 0);
        trig_level_i = 100; trig_edge_i = 0; post_len_i = 5;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 70, 0, i == 2);
            checks++;
            if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
                errors++;
                $display("FAIL force[%0d]: got %h expected %h", i, {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
            end
            if (i == 2) begin
                checks++;
                if (triggered_o !== 1'b1 || wr_en_o !== 1'b1 || wr_data_o !== 8'd70) begin
                    errors++;
                    $display("FAIL force_start: got trig=%b wr_en=%b data=%0d expected 1 1 70", triggered_o, wr_en_o, wr_data_o);
                end
            end
        end
        step(1, 1, 1, 80, 0, 0);
        checks++;
        if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || triggered_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort: got wr_en=%b busy=%b trig=%b done=%b expected 0 0 0 0", wr_en_o, busy_o, triggered_o, done_o);
        end
        post_len_i = 0;
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (busy_o !== 1'b0 || {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
            errors++;
            $display("FAIL arm_zero_len: got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_async_reset();
        post_len_i = 6; trig_level_i = 100;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 33, 0, 1);
        step(0, 0, 1, 34, 1, 0);
        #2;
        rst_i = 1;
        model_reset();
        #1;
        checks++;
        if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, 13'h0);
        end
        @(negedge clk_i); rst_i = 0;
        step(0, 0, 1, 150, 0, 0);
        checks++;
        if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset_idle: got %h expected %h", {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
        end
    endtask

    task automatic test_random();
        bit arm, abort, valid, full, frc;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                trig_level_i = 8'($urandom_range(0, 255));
                trig_edge_i  = 1'($urandom_range(0, 1));
            end
            post_len_i = 12'($urandom_range(0, 5));
            arm   = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 59) == 0);
            valid = ($urandom_range(0, 3) != 0);
            full  = ($urandom_range(0, 4) == 0);
            frc   = ($urandom_range(0, 15) == 0);
            step(arm, abort, valid, int'($urandom_range(0, 255)), full, frc);
            checks++;
            if ({wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o} !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, {wr_en_o, wr_data_o, busy_o, triggered_o, done_o, overflow_o}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_overflow();
        test_rearm();
        test_force_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
